float_to_int_arbiter: RTL and testbench
=======================================

# float_to_int_arbiter

Shares one float-to-int conversion datapath between `NUM_REQ` requesters. Each requester submits an IEEE-754 single-precision operand over a valid/ready handshake, and a round-robin arbiter grants one requester per cycle. The granted operand is converted and held in a one-entry output register, and the result is returned on a single response channel tagged with the requester index. The block sits between the scalar issue ports and the shared conversion resource, so no requester needs its own converter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16).
- `ID_W`, `$clog2(NUM_REQ)`: width of the response tag (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high per cycle.
- `req_data`  in  `32*NUM_REQ`  operands; requester i uses bits `[32*i+31:32*i]`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_data`  out  32  signed int32 result.
- `rsp_id`  out  `ID_W`  index of the requester that produced this result.
- `rsp_ovf`  out  1  saturation occurred (overflow, Inf or NaN).

## Operation
- **Conversion rules:** truncate toward zero.
  - Exponent field 0 (zero or denormal) gives 0.
  - Unbiased exponent < 0 (|x| < 1) gives 0.
  - Otherwise the magnitude is `{1, mantissa}` shifted by (exp - 150): left when exp > 150, right when exp ≤ 150.
  - Negative sign gives the two's complement of the magnitude.
- **Saturation:** unbiased exponent > 30, including Inf and NaN, gives `0x7FFFFFFF` when the sign is 0 and `0x80000000` when the sign is 1. `rsp_ovf` is set in every such case.
- **Unbiased exponent:** computed as a signed 9-bit value, exp - 127. It must never wrap through unsigned 8-bit arithmetic.
- **`load` signal:** `load = !rsp_valid || rsp_ready`. The output slot is free, or is being drained in the same cycle.
- **Arbitration:**
  - Among asserted `req_valid` bits, grant the first one found searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready[g] = load` for the granted g only; every other bit is 0.
  - `req_ready` does not depend on `req_valid` of other requesters beyond grant selection.
  - There is no combinational path from `rsp_ready` to `rsp_data`.
- **Accept:** `req_valid[g] && req_ready[g]`. On accept, the output register loads the converted result, g and the ovf flag, and `rsp_valid` goes to 1. `rr_ptr` becomes (g+1) mod `NUM_REQ`.
- **Drain:** if `rsp_ready && rsp_valid` and no accept occurs in the same cycle, `rsp_valid` goes to 0.
- **Hold:** with `load` = 0, all output registers and `rr_ptr` hold. `rsp_data`, `rsp_id` and `rsp_ovf` stay stable while `rsp_valid && !rsp_ready`.
- **Idle:** with no requests, `rr_ptr` holds.

## Timing
- **Reset values:** `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `rsp_ovf` = 0, `rr_ptr` = 0. During the reset cycle, `req_ready` = 0.
- **Latency:** 1 cycle. Accept at edge N gives `rsp_valid` = 1 after edge N, visible in cycle N+1.
- **Throughput:** 1 result per cycle while `rsp_ready` is held high.
- **Simultaneous drain and accept:** the new result replaces the old one in the same edge, with no bubble.
- **Fairness:** with all requesters continuously valid and `rsp_ready` = 1, grants rotate 0,1,..,N-1,0.
- **Reset mid-operation:** a pending response is discarded. Requesters must re-present their operands, which they do naturally because ready was never seen.
- **Single requester:** a lone valid requester is granted every cycle regardless of `rr_ptr`.

## Structure
- Package `f2i_pkg`:
  - Constants `F32_BIAS`=127, `F32_MANT_W`=23, `I32_MAX`=`32'h7FFFFFFF`, `I32_MIN`=`32'h80000000`.
  - Typedef `f32_t`, a packed struct of sign, exp[7:0] and mant[22:0].
- Sub-module `f2i_core` (combinational): input f32, outputs int32 and ovf. Instantiated once.
- The arbiter, `rr_ptr` and output register live in the top level.

## Test plan
- **Basic conversions:**
  - Requester 0 sends `0x3F800000` (1.0), giving `rsp_data`=1, `rsp_id`=0, ovf=0, one cycle later.
  - `0xC0200000` (-2.5) gives `0xFFFFFFFE`.
  - `0x3F000000` (0.5) gives 0.
- **Saturation boundaries:**
  - `0x4F000000` (2^31) gives `0x7FFFFFFF` with ovf=1.
  - `0xCF000000` gives `0x80000000` with ovf=1.
  - `0x4EFFFFFF` gives `0x7FFFFF80` with ovf=0.
  - `0x7FC00000` (NaN) gives `0x7FFFFFFF` with ovf=1.
- **Round robin:** all 4 requesters valid, `rsp_ready`=1. `rsp_id` sequence is 0,1,2,3,0, one grant per cycle. No requester is granted twice before the others.
- **Backpressure:** `rsp_ready`=0 for 3 cycles with a response pending. `rsp_data`/`rsp_id` stay stable and all `req_ready` stay 0. When `rsp_ready` rises, the next grant is accepted in that same cycle.
- **Reset mid-stream:** `reset` pulses while `rsp_valid`=1. The next cycle shows `rsp_valid`=0, `rr_ptr`=0, and requester 0 wins the next contention.

Source files
------------

// File: rtl/f2i_pkg.sv
// Shared types and constants for the float-to-int conversion slice.
package f2i_pkg;

    localparam int unsigned F32_BIAS   = 127;
    localparam int unsigned F32_MANT_W = 23;
    localparam logic [31:0] I32_MAX    = 32'h7FFFFFFF;
    localparam logic [31:0] I32_MIN    = 32'h80000000;

    // IEEE-754 single-precision operand layout.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } f32_t;

endpackage

// File: rtl/f2i_core.sv
// Combinational single-precision float to int32 conversion, truncating toward zero.
// Ports:
//   op     - IEEE-754 single-precision operand
//   result - signed int32 result, saturated on overflow/Inf/NaN
//   ovf    - saturation occurred
module f2i_core
    import f2i_pkg::*;
(
    input  f32_t        op,
    output logic [31:0] result,
    output logic        ovf
);

    localparam logic signed [8:0] BIAS_S9   = 9'(F32_BIAS);
    localparam logic [7:0]        SHIFT_REF = 8'(F32_BIAS + F32_MANT_W);

    logic signed [8:0] exp_unb;
    logic [31:0]       mant_full;
    logic [31:0]       mag;

    // Unbiased exponent is formed signed so small exponents go negative instead of wrapping.
    always_comb begin
        exp_unb   = $signed({1'b0, op.exp}) - BIAS_S9;
        mant_full = {8'b0, 1'b1, op.mant};
        mag       = '0;
        result    = '0;
        ovf       = 1'b0;
        if (op.exp == 8'd0) begin
            result = '0;
        end else if (exp_unb < 9'sd0) begin
            result = '0;
        end else if (exp_unb > 9'sd30) begin
            ovf    = 1'b1;
            result = op.sign ? I32_MIN : I32_MAX;
        end else begin
            if (op.exp > SHIFT_REF) begin
                mag = mant_full << (op.exp - SHIFT_REF);
            end else begin
                mag = mant_full >> (SHIFT_REF - op.exp);
            end
            result = op.sign ? (~mag + 32'd1) : mag;
        end
    end

endmodule

// File: rtl/float_to_int_arbiter.sv
// Round-robin arbiter sharing one float-to-int converter among NUM_REQ requesters.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (one-hot ready)
//   req_data              - packed operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_ready   - response handshake
//   rsp_data, rsp_id      - int32 result and originating requester index
//   rsp_ovf               - result was saturated
module float_to_int_arbiter
    import f2i_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_ovf
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            grant_found;
    logic            load;
    logic            accept;
    logic [ID_W-1:0] grant_next_ptr;
    f32_t            grant_op;
    logic [31:0]     conv_result;
    logic            conv_ovf;

    assign load = !rsp_valid || rsp_ready;

    // First valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = ID_W'(idx);
            end
        end
    end

    // Ready is suppressed while reset is asserted so nothing is consumed then.
    always_comb begin
        req_ready = '0;
        if (grant_found && !reset) begin
            req_ready[grant] = load;
        end
    end

    assign accept         = grant_found && load && !reset;
    assign grant_op       = f32_t'(req_data[32*grant +: 32]);
    assign grant_next_ptr = (32'(grant) == NUM_REQ - 1) ? '0 : ID_W'(grant + 1'b1);

    f2i_core u_core (
        .op     (grant_op),
        .result (conv_result),
        .ovf    (conv_ovf)
    );

    // Output slot and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_ovf   <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= conv_result;
            rsp_id    <= grant;
            rsp_ovf   <= conv_ovf;
            rr_ptr    <= grant_next_ptr;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_float_to_int_arbiter.sv
// Directed self-checking bench for float_to_int_arbiter.
module tb_float_to_int_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_ovf;

    int n_checks;
    int n_errors;

    float_to_int_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Conversion vectors: requester, operand, expected int, expected ovf.
    localparam int NVEC = 11;
    int          vec_id  [NVEC] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    logic [31:0] vec_in  [NVEC] = '{32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h4F000000,
                                    32'hCF000000, 32'h4EFFFFFF, 32'h7FC00000, 32'h00000001,
                                    32'h4B000001, 32'hFF800000, 32'hBF800000};
    logic [31:0] vec_out [NVEC] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'h7FFFFFFF,
                                    32'h80000000, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h00000000,
                                    32'h00800001, 32'h80000000, 32'hFFFFFFFF};
    logic        vec_ovf [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                    1'b0, 1'b1, 1'b0};

    logic [31:0] rr_ops [NUM_REQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests present that must not be accepted.
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data",  rsp_data, 32'h0);
        check("reset_rsp_id",    32'(rsp_id), 32'h0);
        check("reset_rsp_ovf",   32'(rsp_ovf), 32'h0);
        check("reset_req_ready2", 32'(req_ready), 32'h0);
        reset     = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;

        // Single-requester conversions; one-cycle latency each.
        for (int v = 0; v < NVEC; v++) begin
            req_valid = NUM_REQ'(1) << vec_id[v];
            req_data  = '0;
            req_data[32*vec_id[v] +: 32] = vec_in[v];
            @(negedge clk);
            check($sformatf("conv%0d_req_ready", v), 32'(req_ready), 32'(1) << vec_id[v]);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check($sformatf("conv%0d_valid", v), 32'(rsp_valid), 32'h1);
            check($sformatf("conv%0d_data", v),  rsp_data, vec_out[v]);
            check($sformatf("conv%0d_id", v),    32'(rsp_id), 32'(vec_id[v]));
            check($sformatf("conv%0d_ovf", v),   32'(rsp_ovf), 32'(vec_ovf[v]));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_rsp_valid", 32'(rsp_valid), 32'h0);

        // Fairness: fresh pointer, all requesters valid, consumer always ready.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = rr_ops[i];
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check($sformatf("rr%0d_id", c),   32'(rsp_id), 32'((c - 1) % NUM_REQ));
                check($sformatf("rr%0d_data", c), rsp_data, 32'((c - 1) % NUM_REQ + 1));
            end
            check($sformatf("rr%0d_req_ready", c), 32'(req_ready), 32'(1) << (c % NUM_REQ));
            @(posedge clk); #1;
        end

        // Backpressure: response from requester 1 (value 2) must hold.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", c),     32'(rsp_valid), 32'h1);
            check($sformatf("bp%0d_id", c),        32'(rsp_id), 32'h1);
            check($sformatf("bp%0d_data", c),      rsp_data, 32'h2);
            check($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_id",   32'(rsp_id), 32'h2);
        check("bp_release_data", rsp_data, 32'h3);

        // Reset with a response pending.
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rr_ptr",    32'(dut.rr_ptr), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_id", 32'(rsp_id), 32'h0);

        // Lone requester below the pointer is still granted.
        req_valid = 4'b0001;
        @(negedge clk);
        check("lone_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("lone_id",   32'(rsp_id), 32'h0);
        check("lone_data", rsp_data, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
